fp_mul_seq: RTL and testbench

Parametrised, sequential IEEE 754 floating-point multiplier, the successor to the team's single-precision combinational multiplier. Exponent and fraction widths are generic; significands are multiplied by an iterative radix-2 shift-add datapath. Results are rounded and special operands are classified. Operands and results cross valid/ready handshakes, so the block sits between the operand-issue logic and the result writeback queue.

---
 rtl/fp_mul_seq.sv | 176 +++++++++++++++++
 tb/tb_fp_mul_seq.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/fp_mul_seq.sv
// Sequential IEEE 754 multiplier: radix-2 shift-add significand product, then normalise/round.
// Define FP_MUL_ROUND_EN for round-to-nearest-even; otherwise results are truncated.
module fp_mul_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in1,
    input  logic [EXP_W+MAN_W:0]   in2,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out,
    output logic [3:0]             flags
);

    localparam int SIG_W  = MAN_W + 1;
    localparam int PROD_W = 2 * MAN_W + 2;
    localparam int CNT_W  = $clog2(SIG_W);
    localparam int XW     = EXP_W + 2;

    localparam logic signed [XW-1:0] BIAS_X = XW'((2 ** (EXP_W - 1)) - 1);
    localparam logic signed [XW-1:0] EMAX_X = XW'((2 ** EXP_W) - 1);
    localparam logic signed [XW-1:0] ONE_X  = XW'(1);
    localparam logic [EXP_W+MAN_W:0] QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

`ifdef FP_MUL_ROUND_EN
    localparam logic ROUND_NE = 1'b1;
`else
    localparam logic ROUND_NE = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, MUL, ROUND, DONE} state_t;

    state_t              state;
    logic                sign_q;
    logic [EXP_W-1:0]    exp1_q, exp2_q;
    logic [SIG_W-1:0]    sig1_q, sig2_q;
    logic [PROD_W-1:0]   acc;
    logic [CNT_W-1:0]    count;

    logic [EXP_W-1:0]    exp1, exp2;
    logic [MAN_W-1:0]    frac1, frac2;
    logic                nan1, nan2, inf1, inf2, zero1, zero2, sign_in;
    logic                spec_hit;
    logic [EXP_W+MAN_W:0] spec_out;
    logic [3:0]          spec_flags;

    assign exp1    = in1[EXP_W+MAN_W-1 -: EXP_W];
    assign exp2    = in2[EXP_W+MAN_W-1 -: EXP_W];
    assign frac1   = in1[MAN_W-1:0];
    assign frac2   = in2[MAN_W-1:0];
    assign sign_in = in1[EXP_W+MAN_W] ^ in2[EXP_W+MAN_W];
    assign nan1    = (&exp1) && (|frac1);
    assign nan2    = (&exp2) && (|frac2);
    assign inf1    = (&exp1) && !(|frac1);
    assign inf2    = (&exp2) && !(|frac2);
    assign zero1   = (exp1 == '0);
    assign zero2   = (exp2 == '0);

    // NaN and inf*zero take priority over the plain infinity and zero cases
    always_comb begin
        spec_hit   = 1'b0;
        spec_out   = '0;
        spec_flags = '0;
        if (nan1 || nan2 || (inf1 && zero2) || (zero1 && inf2)) begin
            spec_hit   = 1'b1;
            spec_out   = QNAN;
            spec_flags = 4'b1000;
        end else if (inf1 || inf2) begin
            spec_hit = 1'b1;
            spec_out = {sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (zero1 || zero2) begin
            spec_hit = 1'b1;
            spec_out = {sign_in, {(EXP_W+MAN_W){1'b0}}};
        end
    end

    logic                 norm, guard, sticky, rnd_inc, inexact;
    logic [PROD_W-2:0]    shifted;
    logic [MAN_W-1:0]     frac;
    logic [MAN_W:0]       rounded;
    logic signed [XW-1:0] exp_sum, exp_fin;
    logic [EXP_W+MAN_W:0] res_out;
    logic [3:0]           res_flags;

    // Product lies in [1,4); after alignment the fraction sits just below the leading one
    always_comb begin
        norm    = acc[PROD_W-1];
        shifted = norm ? acc[PROD_W-2:0] : {acc[PROD_W-3:0], 1'b0};
        frac    = shifted[PROD_W-2 -: MAN_W];
        guard   = shifted[PROD_W-2-MAN_W];
        sticky  = |shifted[PROD_W-3-MAN_W:0];
        inexact = guard | sticky;
        rnd_inc = ROUND_NE & guard & (sticky | frac[0]);
        rounded = {1'b0, frac} + {{MAN_W{1'b0}}, rnd_inc};
        exp_sum = $signed({2'b00, exp1_q}) + $signed({2'b00, exp2_q}) - BIAS_X
                  + $signed({{(XW-1){1'b0}}, norm});
        exp_fin = exp_sum + $signed({{(XW-1){1'b0}}, rounded[MAN_W]});
        if (exp_fin >= EMAX_X) begin
            res_out   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            res_flags = 4'b0101;
        end else if (exp_fin < ONE_X) begin
            res_out   = {sign_q, {(EXP_W+MAN_W){1'b0}}};
            res_flags = 4'b0011;
        end else begin
            res_out   = {sign_q, exp_fin[EXP_W-1:0], rounded[MAN_W-1:0]};
            res_flags = {3'b000, inexact};
        end
    end

    assign in_ready = (state == IDLE);

    // Special results enter DONE with out_valid still low so they surface one edge later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out       <= '0;
            flags     <= '0;
            acc       <= '0;
            count     <= '0;
            sign_q    <= 1'b0;
            exp1_q    <= '0;
            exp2_q    <= '0;
            sig1_q    <= '0;
            sig2_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_q <= sign_in;
                        exp1_q <= exp1;
                        exp2_q <= exp2;
                        sig1_q <= {1'b1, frac1};
                        sig2_q <= {1'b1, frac2};
                        acc    <= '0;
                        count  <= '0;
                        if (spec_hit) begin
                            out   <= spec_out;
                            flags <= spec_flags;
                            state <= DONE;
                        end else begin
                            state <= MUL;
                        end
                    end
                end
                MUL: begin
                    if (sig2_q[count])
                        acc <= acc + (PROD_W'(sig1_q) << count);
                    count <= count + 1'b1;
                    if (count == CNT_W'(MAN_W))
                        state <= ROUND;
                end
                ROUND: begin
                    out       <= res_out;
                    flags     <= res_flags;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed-vector bench for fp_mul_seq (single precision), with hand-computed products.
module tb_fp_mul_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in1 = '0;
    logic [31:0] in2 = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out;
    logic [3:0]  flags;

    int checks = 0;
    int failures = 0;

`ifdef FP_MUL_ROUND_EN
    localparam logic [31:0] TIE_RESULT = 32'h3FC0_0002;
`else
    localparam logic [31:0] TIE_RESULT = 32'h3FC0_0001;
`endif

    fp_mul_seq #(.EXP_W(8), .MAN_W(23)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in1      (in1),
        .in2      (in2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out),
        .flags    (flags)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One full transaction: accept, measure latency, check result, drain
    task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] exp_out, input logic [3:0] exp_flags,
                                 input int exp_lat);
        int edges;
        checkOutput({tag, "_rdy"}, {31'b0, in_ready}, 32'd1);
        in1 = a;
        in2 = b;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in1 = 32'hDEAD_BEEF;
        in2 = 32'h1234_5678;
        edges = 0;
        while (!out_valid && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
        checkOutput({tag, "_lat"}, edges, exp_lat);
        checkOutput({tag, "_out"}, out, exp_out);
        checkOutput({tag, "_flags"}, {28'b0, flags}, {28'b0, exp_flags});
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput({tag, "_drain"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        int edges;
        $display("[TB] starting fp_mul_seq bench");
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_out", out, 32'd0);
        checkOutput("rst_flags", {28'b0, flags}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        applyStimulus("basic",    32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 25);
        applyStimulus("tie",      32'h3F80_0001, 32'h3FC0_0000, TIE_RESULT,     4'b0001, 25);
        applyStimulus("norm",     32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 4'b0000, 25);
        applyStimulus("neg",      32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, 4'b0000, 25);
        applyStimulus("inf_zero", 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000, 1);
        applyStimulus("ninf",     32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 4'b0000, 1);
        applyStimulus("nan",      32'h7FC1_2345, 32'h3F80_0000, 32'h7FC0_0000, 4'b1000, 1);
        applyStimulus("nzero",    32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 4'b0000, 1);
        applyStimulus("ovf",      32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 4'b0101, 25);
        applyStimulus("unf",      32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 4'b0011, 25);

        // Backpressure: result must hold while new operands are offered and ignored
        in1 = 32'h3FC0_0000;
        in2 = 32'h4000_0000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        edges = 0;
        while (!out_valid && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
        checkOutput("bp_lat", edges, 32'd25);
        in1 = 32'h7F80_0000;
        in2 = 32'h0000_0000;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checkOutput("bp_out", out, 32'h4040_0000);
            checkOutput("bp_flags", {28'b0, flags}, 32'd0);
            checkOutput("bp_in_ready", {31'b0, in_ready}, 32'd0);
            checkOutput("bp_out_valid", {31'b0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("bp_drain", {31'b0, out_valid}, 32'd0);
        checkOutput("bp_idle", {31'b0, in_ready}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("bp_no_ghost", {31'b0, out_valid}, 32'd0);

        // Mid-multiply reset aborts the operation asynchronously
        in1 = 32'h3FC0_0000;
        in2 = 32'h4000_0000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("abort_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("abort_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("abort_out", out, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        applyStimulus("post_rst", 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 25);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
